// File: rtl/lcd_text_frame_pkg.sv
// Shared LCD constants and the frame-render FSM encoding.
package lcd_pkg;

  localparam logic       LCD_RS_DATA     = 1'b1;
  localparam logic [7:0] ASCII_SPACE     = 8'h20;
  localparam logic [7:0] ASCII_ZERO      = 8'h30;
  localparam int         LCD_FRAME_CHARS = 32;
  localparam int         LCD_LINE_CHARS  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_WRITE = 2'd2
  } frame_state_e;

endpackage

// File: rtl/lcd_text_frame_bin2bcd.sv
// Sequential double-dabble: one value bit per clock, MSB first; bcd holds after done.
module bin2bcd_seq #(
  parameter int NUM_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic                  start,
  input  logic [NUM_W-1:0]      value,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = (NUM_W > 1) ? $clog2(NUM_W) : 1;

  logic [NUM_W-1:0]    val_r;
  logic [4*DIGITS-1:0] bcd_r;
  logic [4*DIGITS-1:0] adj_s;
  logic [CW-1:0]       cnt_r;
  logic                busy_r;
  logic                done_r;

  // Add-3 correction on every nibble that would overflow past 9 after the shift.
  always_comb begin
    adj_s = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = bcd_r[4*i +: 4];
      end
    end
  end

  // Conversion state: latch on start, shift NUM_W times, pulse done.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      val_r  <= '0;
      bcd_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (abort) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      val_r  <= value;
      bcd_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      bcd_r <= {adj_s[4*DIGITS-2:0], val_r[NUM_W-1]};
      val_r <= val_r << 1;
      cnt_r <= cnt_r + CW'(1);
      if (cnt_r == CW'(NUM_W - 1)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign bcd  = bcd_r;

endmodule

// File: rtl/lcd_text_frame.sv
// 32-entry LCD frame buffer with host writes, clear, and right-aligned decimal rendering.
module lcd_text_frame
  import lcd_pkg::*;
#(
  parameter int         NUM_W     = 16,
  parameter int         DIGITS    = 5,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iWR,
  input  logic [4:0]         iADDR,
  input  logic [7:0]         iCHAR,
  input  logic               iCLR,
  input  logic               iNUM_START,
  input  logic [NUM_W-1:0]   iNUM_VAL,
  input  logic [4:0]         iNUM_POS,
  input  logic               iNUM_BLANK,
  output logic               oBUSY,
  output logic               oDONE,
  output logic [287:0]       oFRAME
);

  localparam int         KW         = $clog2(DIGITS + 1);
  localparam logic [8:0] FILL_ENTRY = {LCD_RS_DATA, FILL_CHAR};

  frame_state_e        state_r;
  logic [4:0]          pos_r;
  logic                blank_r;
  logic                seen_nz_r;
  logic [KW-1:0]       k_r;
  logic                busy_r;
  logic                done_r;
  logic [8:0]          frame_r [LCD_FRAME_CHARS];

  logic                conv_start_s;
  logic                conv_busy_s;
  logic                conv_done_s;
  logic [4*DIGITS-1:0] bcd_s;
  logic                eng_we_s;
  logic [KW-1:0]       eng_k_s;
  logic [3:0]          digit_s;
  logic                blank_s;
  logic [4:0]          eng_addr_s;
  logic [8:0]          eng_word_s;

  assign conv_start_s = (state_r == ST_IDLE) && iNUM_START && !iCLR && !conv_busy_s;

  bin2bcd_seq #(.NUM_W(NUM_W), .DIGITS(DIGITS)) u_bin2bcd (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .start  (conv_start_s),
    .value  (iNUM_VAL),
    .abort  (iCLR),
    .busy   (conv_busy_s),
    .done   (conv_done_s),
    .bcd    (bcd_s)
  );

  // Digit 0 is written on the CONV->WRITE edge, the rest from WRITE.
  always_comb begin
    eng_we_s = 1'b0;
    eng_k_s  = k_r;
    case (state_r)
      ST_CONV: begin
        eng_we_s = conv_done_s && !iCLR;
        eng_k_s  = '0;
      end
      ST_WRITE: begin
        eng_we_s = !iCLR;
        eng_k_s  = k_r;
      end
      default: begin
        eng_we_s = 1'b0;
        eng_k_s  = k_r;
      end
    endcase
    digit_s    = 4'(bcd_s >> (4 * (DIGITS - 1 - int'(eng_k_s))));
    blank_s    = blank_r && !seen_nz_r && (digit_s == 4'd0) && (eng_k_s != KW'(DIGITS - 1));
    eng_addr_s = pos_r + 5'(eng_k_s);
    if (blank_s) begin
      eng_word_s = FILL_ENTRY;
    end else begin
      eng_word_s = {LCD_RS_DATA, ASCII_ZERO + {4'd0, digit_s}};
    end
  end

  // Render sequencer: IDLE -> CONV -> WRITE, clear aborts from any state.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r   <= ST_IDLE;
      pos_r     <= 5'd0;
      blank_r   <= 1'b0;
      seen_nz_r <= 1'b0;
      k_r       <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else if (iCLR) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (conv_start_s) begin
            pos_r     <= iNUM_POS;
            blank_r   <= iNUM_BLANK;
            seen_nz_r <= 1'b0;
            k_r       <= '0;
            busy_r    <= 1'b1;
            state_r   <= ST_CONV;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_CONV: begin
          done_r <= 1'b0;
          if (conv_done_s) begin
            seen_nz_r <= seen_nz_r | (digit_s != 4'd0);
            k_r       <= KW'(1);
            state_r   <= ST_WRITE;
          end else begin
            state_r <= ST_CONV;
          end
        end
        ST_WRITE: begin
          seen_nz_r <= seen_nz_r | (digit_s != 4'd0);
          if (k_r == KW'(DIGITS - 1)) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            k_r     <= k_r + KW'(1);
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Frame storage: clear beats everything, engine write beats a host write to the same entry.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < LCD_FRAME_CHARS; i++) frame_r[i] <= FILL_ENTRY;
    end else if (iCLR) begin
      for (int i = 0; i < LCD_FRAME_CHARS; i++) frame_r[i] <= FILL_ENTRY;
    end else begin
      if (iWR) frame_r[iADDR] <= {LCD_RS_DATA, iCHAR};
      if (eng_we_s) frame_r[eng_addr_s] <= eng_word_s;
    end
  end

  // Flatten the frame onto the output bus.
  always_comb begin
    oFRAME = '0;
    for (int i = 0; i < LCD_FRAME_CHARS; i++) oFRAME[9*i +: 9] = frame_r[i];
  end

  assign oBUSY = busy_r;
  assign oDONE = done_r;

endmodule
